// File: rtl/skrach_axil_pkg.sv
// Shared types, response codes and helpers for the skrach AXI4-Lite register controller.
package skrach_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned REG_CTRL   = 32'd0;
  localparam int unsigned REG_FREQ   = 32'd1;
  localparam int unsigned REG_ENV    = 32'd2;
  localparam int unsigned REG_STATUS = 32'd3;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_COMMIT = 2'd1,
    W_RESP   = 2'd2
  } wr_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Index width for n registers, never narrower than one bit.
  function automatic int unsigned reg_idx_w(input int unsigned n);
    int unsigned w;
    w = 32'd1;
    for (int unsigned i = 32'd1; i < 32'd32; i++) begin
      if ((32'd1 << i) < n) begin
        w = i + 32'd1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  function automatic logic [31:0] merge_strb(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/skrach_reg_bank.sv
// Register storage with byte-strobe merge and AXI-over-core arbitration per register.
module skrach_reg_bank
  import skrach_axil_pkg::*;
#(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned IDX_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   axi_we,
  input  logic [IDX_W-1:0]       axi_idx,
  input  logic [31:0]            axi_wdata,
  input  logic [3:0]             axi_wstrb,
  input  logic                   core_valid,
  input  logic [IDX_W-1:0]       core_idx,
  input  logic [31:0]            core_data,
  output logic [NUM_REGS*32-1:0] reg_out,
  output logic [NUM_REGS-1:0]    wr_pulse,
  output logic                   core_drop
);

  logic [NUM_REGS-1:0][31:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]       wr_pulse_q, wr_pulse_d;
  logic                      core_drop_q, core_drop_d;
  logic                      core_in_range_s;
  logic                      conflict_s;

  assign core_in_range_s = (32'(core_idx) < NUM_REGS);
  assign conflict_s      = axi_we && (axi_idx == core_idx);

  // Next register state: the core update is applied first, an AXI commit to the same index overrides it.
  always_comb begin
    regs_d      = regs_q;
    wr_pulse_d  = '0;
    core_drop_d = 1'b0;
    if (core_valid && core_in_range_s) begin
      if (conflict_s) begin
        core_drop_d = 1'b1;
      end else begin
        regs_d[core_idx] = core_data;
      end
    end else begin
      core_drop_d = 1'b0;
    end
    if (axi_we) begin
      regs_d[axi_idx]     = merge_strb(regs_q[axi_idx], axi_wdata, axi_wstrb);
      wr_pulse_d[axi_idx] = 1'b1;
    end else begin
      wr_pulse_d = '0;
    end
  end

  // Register storage and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q      <= '0;
      wr_pulse_q  <= '0;
      core_drop_q <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      wr_pulse_q  <= wr_pulse_d;
      core_drop_q <= core_drop_d;
    end
  end

  assign reg_out   = regs_q;
  assign wr_pulse  = wr_pulse_q;
  assign core_drop = core_drop_q;

endmodule

// File: rtl/skrach_axil_reg_ctrl.sv
// AXI4-Lite slave front end for the skrach_core register file: independent write and read FSMs.
module skrach_axil_reg_ctrl
  import skrach_axil_pkg::*;
#(
  parameter  int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter  int unsigned C_S_AXI_ADDR_WIDTH = 5,
  parameter  int unsigned NUM_REGS           = 4,
  localparam int unsigned IDX_W              = reg_idx_w(NUM_REGS)
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            core_upd_valid,
  input  logic [IDX_W-1:0]                core_upd_idx,
  input  logic [31:0]                     core_upd_data,
  output logic                            core_upd_drop,
  output logic [NUM_REGS*32-1:0]          reg_out,
  output logic [NUM_REGS-1:0]             reg_wr_pulse
);

  localparam int unsigned WA_W = C_S_AXI_ADDR_WIDTH - 2;

  wr_state_t   wr_state_q, wr_state_d;
  logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [WA_W-1:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;

  rd_state_t   rd_state_q, rd_state_d;
  logic        arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;

  logic aw_hs_s, w_hs_s, ar_hs_s, aw_in_range_s, ar_in_range_s, axi_we_s;
  logic [WA_W-1:0]           ar_waddr_s;
  logic [NUM_REGS*32-1:0]    reg_out_s;
  logic [NUM_REGS-1:0][31:0] regs_view_s;
  logic                      unused_s;

  assign aw_hs_s       = S_AXI_AWVALID && awready_q;
  assign w_hs_s        = S_AXI_WVALID && wready_q;
  assign ar_hs_s       = S_AXI_ARVALID && arready_q;
  assign ar_waddr_s    = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign aw_in_range_s = (32'(awaddr_q) < NUM_REGS);
  assign ar_in_range_s = (32'(ar_waddr_s) < NUM_REGS);
  assign axi_we_s      = (wr_state_q == W_COMMIT) && aw_in_range_s;
  assign regs_view_s   = reg_out_s;
  assign unused_s      = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  skrach_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_bank (
    .clk        (ACLK),
    .rst_n      (ARESETN),
    .axi_we     (axi_we_s),
    .axi_idx    (awaddr_q[IDX_W-1:0]),
    .axi_wdata  (wdata_q),
    .axi_wstrb  (wstrb_q),
    .core_valid (core_upd_valid),
    .core_idx   (core_upd_idx),
    .core_data  (core_upd_data),
    .reg_out    (reg_out_s),
    .wr_pulse   (reg_wr_pulse),
    .core_drop  (core_upd_drop)
  );

  // Write FSM next state: AW and W are captured independently, in any order.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs_s) begin
          aw_held_d = 1'b1;
          awaddr_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
        end else begin
          aw_held_d = aw_held_q;
        end
        if (w_hs_s) begin
          w_held_d = 1'b1;
          wdata_d  = S_AXI_WDATA;
          wstrb_d  = S_AXI_WSTRB;
        end else begin
          w_held_d = w_held_q;
        end
        if (aw_held_d && w_held_d) begin
          wr_state_d = W_COMMIT;
          awready_d  = 1'b0;
          wready_d   = 1'b0;
        end else begin
          awready_d = ~aw_held_d;
          wready_d  = ~w_held_d;
        end
      end
      W_COMMIT: begin
        wr_state_d = W_RESP;
        aw_held_d  = 1'b0;
        w_held_d   = 1'b0;
        bvalid_d   = 1'b1;
        bresp_d    = aw_in_range_s ? RESP_OKAY : RESP_SLVERR;
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          wr_state_d = W_IDLE;
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
        end else begin
          bvalid_d = 1'b1;
        end
      end
      default: begin
        wr_state_d = W_IDLE;
        aw_held_d  = 1'b0;
        w_held_d   = 1'b0;
        awready_d  = 1'b0;
        wready_d   = 1'b0;
        bvalid_d   = 1'b0;
      end
    endcase
  end

  // Read FSM next state: data is sampled from the registers at the AR handshake edge.
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          rd_state_d = R_DATA;
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          if (ar_in_range_s) begin
            rdata_d = regs_view_s[ar_waddr_s[IDX_W-1:0]];
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = 32'h0000_0000;
            rresp_d = RESP_SLVERR;
          end
        end else begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rd_state_d = R_IDLE;
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
        end else begin
          rvalid_d = 1'b1;
        end
      end
      default: begin
        rd_state_d = R_IDLE;
        arready_d  = 1'b0;
        rvalid_d   = 1'b0;
      end
    endcase
  end

  // FSM state and registered AXI outputs.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state_q <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= 32'h0000_0000;
      wstrb_q    <= 4'h0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= 2'b00;
      rdata_q    <= 32'h0000_0000;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign reg_out       = reg_out_s;

endmodule

// File: tb/tb_skrach_axil_reg_ctrl.sv
// Table-driven bench for skrach_axil_reg_ctrl plus hand-written multi-cycle sequences.
module tb_skrach_axil_reg_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [4:0]   awaddr = 5'h00;
  logic [2:0]   awprot = 3'b000;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [31:0]  wdata = 32'h0;
  logic [3:0]   wstrb = 4'h0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b0;
  logic [4:0]   araddr = 5'h00;
  logic [2:0]   arprot = 3'b000;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready = 1'b0;
  logic         core_upd_valid = 1'b0;
  logic [1:0]   core_upd_idx = 2'd0;
  logic [31:0]  core_upd_data = 32'h0;
  logic         core_upd_drop;
  logic [127:0] reg_out;
  logic [3:0]   reg_wr_pulse;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int drop_cnt = 0;
  int pulse_cnt [4] = '{0, 0, 0, 0};
  int pre_cnt [4];

  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  skrach_axil_reg_ctrl dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .core_upd_valid(core_upd_valid), .core_upd_idx(core_upd_idx), .core_upd_data(core_upd_data),
    .core_upd_drop(core_upd_drop), .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) pulse_cnt[i] = pulse_cnt[i] + int'(reg_wr_pulse[i]);
      drop_cnt = drop_cnt + int'(core_upd_drop);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic bound_fail(input string name);
    n_total++;
    $display("FAIL %s: wait bound expired, required handshake", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat);
    bit aw_done = 0, w_done = 0;
    bit aw_hs, w_hs;
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    resp = 2'bxx; lat = -1;
    while (!(aw_done && w_done) && n < 20) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
      if (w_hs)  begin wvalid = 1'b0;  w_done = 1;  end
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) begin
      bound_fail("aw_w_handshake");
    end else begin
      bready = 1'b1;
      n = 1;
      while (!bvalid && n < 20) begin tick(); n++; end
      if (!bvalid) bound_fail("bvalid_wait");
      else begin
        lat = n;
        resp = bresp;
        tick();
      end
      bready = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r,
                          output logic rv_at_1);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    d = 32'hx; r = 2'bxx; rv_at_1 = 1'b0;
    while (!arready && n < 20) begin tick(); n++; end
    if (!arready) begin
      bound_fail("arready_wait");
      arvalid = 1'b0;
    end else begin
      tick();
      arvalid = 1'b0;
      rv_at_1 = rvalid;
      d = rdata; r = rresp;
      rready = 1'b1;
      tick();
      rready = 1'b0;
    end
  endtask

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  bresp;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  pulse;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [1:0]  resp;
    logic [31:0] d;
    logic        rv;
    logic [15:0] got_p, exp_p;
    int          lat, t0, n;
    bit          stable;

    vecs[0] = '{5'h00, 32'h0000_0001, 4'hF, OKAY,   32'h0000_0001, OKAY,   4'b0001};
    vecs[1] = '{5'h04, 32'h0000_0002, 4'hF, OKAY,   32'h0000_0002, OKAY,   4'b0010};
    vecs[2] = '{5'h08, 32'h0000_0003, 4'hF, OKAY,   32'h0000_0003, OKAY,   4'b0100};
    vecs[3] = '{5'h0C, 32'h0000_0004, 4'hF, OKAY,   32'h0000_0004, OKAY,   4'b1000};
    vecs[4] = '{5'h04, 32'hFFFF_FFFF, 4'hF, OKAY,   32'hFFFF_FFFF, OKAY,   4'b0010};
    vecs[5] = '{5'h04, 32'h1234_5678, 4'h5, OKAY,   32'hFF34_FF78, OKAY,   4'b0010};
    vecs[6] = '{5'h10, 32'hCAFE_F00D, 4'hF, SLVERR, 32'h0000_0000, SLVERR, 4'b0000};
    vecs[7] = '{5'h1E, 32'h0BAD_0BAD, 4'hF, SLVERR, 32'h0000_0000, SLVERR, 4'b0000};
    vecs[8] = '{5'h0D, 32'hA5A5_A5A5, 4'h8, OKAY,   32'hA500_0004, OKAY,   4'b1000};

    // Reset state
    repeat (3) tick();
    check("rst_ready_valid", {awready, wready, bvalid, arready, rvalid}, 5'b00000);
    check("rst_resp_data", {bresp, rresp, rdata}, 36'h0);
    check("rst_reg_out", reg_out, 128'h0);
    check("rst_pulse_drop", {reg_wr_pulse, core_upd_drop}, 5'b00000);
    rst_n = 1'b1;
    repeat (3) tick();

    // Table: write, read back, strobes and responses
    for (int v = 0; v < 9; v++) begin
      for (int k = 0; k < 4; k++) pre_cnt[k] = pulse_cnt[k];
      axi_write(vecs[v].addr, vecs[v].data, vecs[v].strb, resp, lat);
      check($sformatf("v%0d_bresp", v), resp, vecs[v].bresp);
      check($sformatf("v%0d_b_latency", v), lat, 2);
      for (int k = 0; k < 4; k++) begin
        got_p[4*k +: 4] = 4'(pulse_cnt[k] - pre_cnt[k]);
        exp_p[4*k +: 4] = {3'b000, vecs[v].pulse[k]};
      end
      check($sformatf("v%0d_wr_pulse", v), got_p, exp_p);
      axi_read(vecs[v].addr, d, resp, rv);
      check($sformatf("v%0d_rvalid_latency", v), rv, 1'b1);
      check($sformatf("v%0d_rdata", v), d, vecs[v].rdata);
      check($sformatf("v%0d_rresp", v), resp, vecs[v].rresp);
    end
    check("table_reg_out", reg_out, {32'hA500_0004, 32'h0000_0003, 32'hFF34_FF78, 32'h0000_0001});

    // W arrives three cycles before AW, then BREADY held low
    for (int k = 0; k < 4; k++) pre_cnt[k] = pulse_cnt[k];
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1; t0 = cyc;
    tick(); wvalid = 1'b0;
    repeat (2) tick();
    awaddr = 5'h08; awvalid = 1'b1;
    tick(); awvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 10) begin tick(); n++; end
    check("w_first_bvalid_cycle", cyc - t0, 5);
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bvalid !== 1'b1 || bresp !== OKAY) stable = 0;
    end
    check("b_stall_hold", stable, 1'b1);
    bready = 1'b1; tick(); bready = 1'b0;
    check("b_released", bvalid, 1'b0);
    check("w_first_one_commit", pulse_cnt[2] - pre_cnt[2], 1);
    check("w_first_reg2", reg_out[95:64], 32'hDEAD_BEEF);

    // AXI commit and core update to the same register in one cycle
    n = drop_cnt;
    awaddr = 5'h08; wdata = 32'h0000_AAAA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick(); awvalid = 1'b0; wvalid = 1'b0;
    core_upd_valid = 1'b1; core_upd_idx = 2'd2; core_upd_data = 32'h0000_5555;
    tick(); core_upd_valid = 1'b0;
    bready = 1'b1; tick(); bready = 1'b0;
    tick();
    check("arb_same_reg2", reg_out[95:64], 32'h0000_AAAA);
    check("arb_same_drop", drop_cnt - n, 1);

    // Core update to a different register in the commit cycle
    n = drop_cnt; pre_cnt[3] = pulse_cnt[3];
    awaddr = 5'h08; wdata = 32'h0000_BBBB; awvalid = 1'b1; wvalid = 1'b1;
    tick(); awvalid = 1'b0; wvalid = 1'b0;
    core_upd_valid = 1'b1; core_upd_idx = 2'd3; core_upd_data = 32'h0000_5555;
    tick(); core_upd_valid = 1'b0;
    bready = 1'b1; tick(); bready = 1'b0;
    tick();
    check("arb_diff_regs", reg_out[127:64], {32'h0000_5555, 32'h0000_BBBB});
    check("arb_diff_no_drop", drop_cnt - n, 0);
    check("core_upd_no_pulse", pulse_cnt[3] - pre_cnt[3], 0);

    // Read in the same cycle as a core update to reg0, RREADY held low
    araddr = 5'h00; arvalid = 1'b1;
    core_upd_valid = 1'b1; core_upd_idx = 2'd0; core_upd_data = 32'h0000_0077;
    tick(); arvalid = 1'b0; core_upd_valid = 1'b0;
    check("rd_pre_update_rvalid", rvalid, 1'b1);
    check("rd_pre_update_rdata", rdata, 32'h0000_0001);
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rvalid !== 1'b1 || rdata !== 32'h0000_0001 || rresp !== OKAY || arready !== 1'b0) stable = 0;
    end
    check("r_stall_hold", stable, 1'b1);
    rready = 1'b1; tick(); rready = 1'b0;
    check("r_released", rvalid, 1'b0);
    check("core_upd_reg0", reg_out[31:0], 32'h0000_0077);

    // Reset asserted while a write response is pending
    awaddr = 5'h0C; wdata = 32'h1111_2222; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick(); awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 10) begin tick(); n++; end
    check("pre_reset_bvalid", bvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_bvalid", bvalid, 1'b0);
    check("mid_reset_regs", reg_out, 128'h0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (2) tick();
    axi_write(5'h08, 32'h1357_9BDF, 4'hF, resp, lat);
    check("post_reset_bresp", resp, OKAY);
    axi_read(5'h08, d, resp, rv);
    check("post_reset_rdata", d, 32'h1357_9BDF);
    check("post_reset_others", {reg_out[127:96], reg_out[63:0]}, 96'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/skrach_axil_reg_ctrl.md
Name: skrach_axil_reg_ctrl

Overview:
AXI4-Lite slave controller that owns the skrach_core register file and sequences every access to it.
- Runs independent write and read FSMs with byte strobes and range checking.
- Arbitrates each register between the AXI master and an internal core-side update port.
- Exports the register contents and per-register write strobes to the synth datapath.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width (only 32 supported)
C_S_AXI_ADDR_WIDTH, 5, AXI byte-address width
NUM_REGS, 4, number of 32-bit registers; valid byte addresses 0x0..(NUM_REGS*4-1)

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake
S_AXI_BRESP  out  2  write response: 00 OKAY, 10 SLVERR
S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake
core_upd_valid  in  1  core requests a register update this cycle
core_upd_idx  in  clog2(NUM_REGS)  target register index
core_upd_data  in  32  full-word update value
core_upd_drop  out  1  one-cycle pulse: core update lost arbitration
reg_out  out  NUM_REGS*32  flat register contents; reg i at [32i+31:32i]
reg_wr_pulse  out  NUM_REGS  one-cycle strobe per register on AXI commit

Behaviour:
- Reset (async assert, sync release): all registers 0; all AXI ready/valid outputs 0; BRESP, RRESP, RDATA 0; core_upd_drop 0; reg_wr_pulse 0; both FSMs to IDLE. Assertion mid-transaction aborts it with no response.
- Write FSM states: W_IDLE, W_COMMIT, W_RESP.
  - W_IDLE: AWREADY is high until an AW beat is captured; WREADY is high until a W beat is captured. AW and W may arrive in either order or in the same cycle. Go to W_COMMIT once both are held.
  - W_COMMIT (one cycle): index = AWADDR[AW-1:2]; AWADDR[1:0] ignored.
    - In range: merge WDATA per WSTRB byte; pulse reg_wr_pulse[index]; BRESP = OKAY.
    - Out of range: no register change; BRESP = SLVERR.
    - Go to W_RESP.
  - W_RESP: BVALID held high until BREADY, then W_IDLE.
  - Latency: AW and W in the same cycle → BVALID 2 cycles later. Back-to-back throughput is 1 write per 3 cycles when BREADY is tied high.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY high. On the AR handshake, register RDATA = reg[index] as held at that edge and set RRESP. Out of range → RDATA 0, RRESP SLVERR.
  - R_DATA: RVALID high with RDATA/RRESP stable until RREADY; ARREADY low.
  - Latency: RVALID 1 cycle after the AR handshake.
- Arbitration, per register, in the commit cycle:
  - An AXI commit to index k beats a same-cycle core update to k. The core update is discarded and core_upd_drop pulses.
  - A core update to a different index in the same cycle is applied.
  - A core update with no conflict is applied at that edge, full word, and does not assert reg_wr_pulse.
  - An out-of-range core_upd_idx is ignored with no drop pulse.
- Read/write ordering: a read handshaking in the same cycle as a commit or core update to the same register returns the pre-update value.
- The write and read FSMs run concurrently. No ordering is enforced between the channels.
- reg_out is driven directly from the registers: updates are visible 1 cycle after the commit or update edge.

Decomposition:
- skrach_axil_pkg holds:
  - RESP_OKAY / RESP_SLVERR constants.
  - wr_state_t and rd_state_t enums.
  - REG_IDX_W = clog2(NUM_REGS) as a function.
  - Register index constants (CTRL, FREQ, ENV, STATUS).
- One sub-module, skrach_reg_bank: storage, strobe merge, core/AXI arbitration, drop pulse. The two FSMs stay in the top.

Test Plan:
- Sequential writes 1,2,3,4 to 0x0,0x4,0x8,0xC, then reads → RDATA 1..4, all BRESP/RRESP OKAY; reg_wr_pulse sees 0001,0010,0100,1000 once each.
- W before AW (W at cycle n, AW at cycle n+3), 0x8 = 0xDEADBEEF → exactly one commit; BVALID at n+5; reg_out[95:64] = 0xDEADBEEF.
- Reg1 = 0xFFFFFFFF, then write 0x12345678 with WSTRB 0101 → read 0xFF34FF78.
- Write and read at 0x10 → BRESP SLVERR, RDATA 0 / RRESP SLVERR, no reg_out change.
- Commit 0xAAAA to reg2 in the same cycle as core_upd idx 2 = 0x5555 → reg2 = 0xAAAA, core_upd_drop pulses once; repeat with core idx 3 → both applied, no drop.
- BREADY/RREADY held low 10 cycles → BVALID/RVALID and data held stable; ARESETN low mid-W_RESP → BVALID 0 immediately, regs 0.
